// File: rtl/sub_pipe_pkg.sv
// Shared helpers for sub_pipe: chunk sizing, status flag type, reset constants.
package sub_pipe_pkg;

   function automatic int chunk_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Signed overflow of a - b: operand signs differ and the result sign differs from a.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

   typedef struct packed {
      logic borrow;
      logic zero;
      logic overflow;
   } status_t;

   localparam logic    VALID_RST  = 1'b0;
   localparam status_t STATUS_RST = '{borrow: 1'b0, zero: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/sub_chunk.sv
// Combinational W-bit borrow-ripple subtract slice: d = a - b - bin, bout = borrow out of MSB.
module sub_chunk
   import sub_pipe_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   logic [W:0] br;

   assign br[0] = bin;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign d[gi]    = a[gi] ^ b[gi] ^ br[gi];
      assign br[gi+1] = (~a[gi] & (b[gi] | br[gi])) | (b[gi] & br[gi]);
   end

   assign bout = br[W];

endmodule

// File: rtl/sub_pipe.sv
// sub_pipe: pipelined WIDTH-bit subtractor, one CHUNK-bit slice per stage, valid/ready handshake.
// Define SUB_PIPE_SATURATE_EN for unsigned saturation (Out forced to 0 whenever BorrowOut is set).
module sub_pipe
   import sub_pipe_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             BorrowIn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic             BorrowOut,
   output logic             Zero,
   output logic             Overflow
);

   localparam int CHUNK = chunk_w(WIDTH, STAGES);
   localparam int LAST  = STAGES - 1;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             borrow;
   } stage_t;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] res;
      status_t          status;
   } out_t;

   localparam stage_t STAGE_RST = '0;

   // link index k is what stage k consumes: index 0 is the port side, k>0 is stage k-1's register.
   logic             link_valid  [STAGES];
   logic [WIDTH-1:0] link_res    [STAGES];
   logic [WIDTH-1:0] link_a      [STAGES];
   logic [WIDTH-1:0] link_b      [STAGES];
   logic             link_borrow [STAGES];
   logic [CHUNK-1:0] chunk_d     [STAGES];
   logic             chunk_bout  [STAGES];

   logic             stall;
   out_t             out_d;
   out_t             out_q;
   logic [WIDTH-1:0] diff_full;
   logic [WIDTH-1:0] res_final;

   assign stall    = out_q.valid && !out_ready;
   assign in_ready = !stall && !rst;

   assign link_valid[0]  = in_valid && in_ready;
   assign link_res[0]    = '0;
   assign link_a[0]      = in1;
   assign link_b[0]      = in2;
   assign link_borrow[0] = BorrowIn;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      sub_chunk #(.W(CHUNK)) u_chunk (
         .a    (link_a[gi][gi*CHUNK +: CHUNK]),
         .b    (link_b[gi][gi*CHUNK +: CHUNK]),
         .bin  (link_borrow[gi]),
         .d    (chunk_d[gi]),
         .bout (chunk_bout[gi])
      );

      if (gi < LAST) begin : g_reg
         stage_t stage_d;
         stage_t stage_q;

         always_comb begin
            stage_d        = STAGE_RST;
            stage_d.valid  = link_valid[gi];
            stage_d.a      = link_a[gi];
            stage_d.b      = link_b[gi];
            stage_d.res    = link_res[gi];
            stage_d.res[gi*CHUNK +: CHUNK] = chunk_d[gi];
            stage_d.borrow = chunk_bout[gi];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               stage_q <= STAGE_RST;
            end else if (!stall) begin
               stage_q.valid <= stage_d.valid;
               if (stage_d.valid) begin
                  stage_q.res    <= stage_d.res;
                  stage_q.a      <= stage_d.a;
                  stage_q.b      <= stage_d.b;
                  stage_q.borrow <= stage_d.borrow;
               end
            end
         end

         assign link_valid[gi+1]  = stage_q.valid;
         assign link_res[gi+1]    = stage_q.res;
         assign link_a[gi+1]      = stage_q.a;
         assign link_b[gi+1]      = stage_q.b;
         assign link_borrow[gi+1] = stage_q.borrow;
      end
   end

   // Final stage: overflow always looks at the modular difference, zero at the delivered value.
   always_comb begin
      diff_full = link_res[LAST];
      diff_full[LAST*CHUNK +: CHUNK] = chunk_d[LAST];
      res_final = diff_full;
`ifdef SUB_PIPE_SATURATE_EN
      if (chunk_bout[LAST]) begin
         res_final = '0;
      end
`endif
      out_d                 = '0;
      out_d.valid           = link_valid[LAST];
      out_d.res             = res_final;
      out_d.status.borrow   = chunk_bout[LAST];
      out_d.status.zero     = (res_final == '0);
      out_d.status.overflow = signed_ovf(link_a[LAST][WIDTH-1], link_b[LAST][WIDTH-1],
                                         diff_full[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q.valid  <= VALID_RST;
         out_q.res    <= '0;
         out_q.status <= STATUS_RST;
      end else if (!stall) begin
         out_q.valid <= out_d.valid;
         if (out_d.valid) begin
            out_q.res    <= out_d.res;
            out_q.status <= out_d.status;
         end
      end
   end

   assign out_valid = out_q.valid;
   assign Out       = out_q.res;
   assign BorrowOut = out_q.status.borrow;
   assign Zero      = out_q.status.zero;
   assign Overflow  = out_q.status.overflow;

endmodule
